// File: rtl/bitmap_drain.sv
// bitmap_drain: accepts a request bitmap and drains it one index per
// cycle, lowest-numbered set bit first, over a valid/ready stream.
// Optional feature macro: BITMAP_DRAIN_MERGE_EN. When it is defined, new
// bitmaps can be accepted during DRAIN and are ORed into the pending set.
module bitmap_drain #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             last_q, last_d;
  logic             take_in;
  logic             take_out;
  logic [WIDTH-1:0] served_mask;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [IDXW-1:0] lowestSet(input logic [WIDTH-1:0] bits);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  // True when exactly one bit is set.
  function automatic logic isSingle(input logic [WIDTH-1:0] bits);
    return (bits != '0) && ((bits & (bits - WIDTH'(1))) == '0);
  endfunction

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
`ifdef BITMAP_DRAIN_MERGE_EN
  assign in_ready  = 1'b1;
`else
  assign in_ready  = (state_q == IDLE);
`endif
  assign take_in     = in_valid & in_ready;
  assign take_out    = out_valid & out_ready;
  assign served_mask = WIDTH'(1) << idx_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;

  // Next pending set, next presented index and state; the presented index
  // only moves on load or on a completed beat, so merges never disturb it.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE: begin
        if (take_in) begin
          pending_d = in_bits;
          idx_d     = lowestSet(in_bits);
          if (in_bits != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (take_out) pending_d = pending_q & ~served_mask;
`ifdef BITMAP_DRAIN_MERGE_EN
        if (take_in) pending_d = pending_d | in_bits;
`endif
        if (take_out) begin
          idx_d = lowestSet(pending_d);
          if (pending_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    last_d = isSingle(pending_d);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_bitmap_drain.sv
// Scoreboard bench for bitmap_drain at WIDTH=8. Expected indices are pushed
// when a bitmap is accepted and popped whenever the DUT completes a beat.
module tb_bitmap_drain;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic            last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             busy;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic            holdValid = 1'b0;
  logic [IDXW-1:0] holdIdx;
  logic            holdLast;

  bitmap_drain #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bits  (in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: set bits in ascending order, last flag on the highest.
  task automatic pushExpected(input logic [WIDTH-1:0] bits);
    int hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < WIDTH; i++) if (bits[i]) hi = i;
    for (int i = 0; i < WIDTH; i++) begin
      if (bits[i]) begin
        e.idx  = IDXW'(i);
        e.last = (i == hi);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic pushOne(input int idx, input logic last);
    exp_t e;
    e.idx  = IDXW'(idx);
    e.last = last;
    expQ.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] bits);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_bits  = bits;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", in_ready, 1'b1);
    if (in_ready) pushExpected(bits);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bits  = '0;
  endtask

  task automatic waitDrain(input bit randomReady);
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy) && n < 300) begin
      if (randomReady) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
    checkOutput("drain_idle", busy, 1'b0);
  endtask

  // Monitor: scoreboard pops on completed beats, hold stability otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid && out_valid) begin
        checkOutput("hold_idx", out_idx, holdIdx);
`ifndef BITMAP_DRAIN_MERGE_EN
        checkOutput("hold_last", out_last, holdLast);
`endif
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_beat", out_valid, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_idx", out_idx, e.idx);
          checkOutput("beat_last", out_last, e.last);
        end
        holdValid = 1'b0;
      end else if (out_valid) begin
        holdValid = 1'b1;
        holdIdx   = out_idx;
        holdLast  = out_last;
      end else begin
        holdValid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] stim[$];

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bits   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_idx", out_idx, 3'd0);
    checkOutput("rst_last", out_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1010_0100 streams 2,5,7 back to back, then idle
    out_ready = 1'b1;
    applyStimulus(8'b1010_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("a4_valid", out_valid, 1'b1);
    end
    @(negedge clk);
    checkOutput("a4_busy", busy, 1'b0);
    checkOutput("a4_inready", in_ready, 1'b1);
    checkOutput("a4_queue", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;

    // Single bit held under backpressure for 5 cycles, then one transfer
    out_ready = 1'b0;
    applyStimulus(8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("h01_valid", out_valid, 1'b1);
      checkOutput("h01_idx", out_idx, 3'd0);
      checkOutput("h01_last", out_last, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("h01_valid6", out_valid, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("h01_idle_valid", out_valid, 1'b0);
    checkOutput("h01_idle_busy", busy, 1'b0);
    checkOutput("h01_queue", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;

    // All-zero bitmap produces no activity
    applyStimulus(8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("zero_busy", busy, 1'b0);
      checkOutput("zero_valid", out_valid, 1'b0);
      checkOutput("zero_ready", in_ready, 1'b1);
    end
    @(posedge clk);
    #1;

    // All-ones drain interrupted by reset after the third transfer
    applyStimulus(8'hFF);
    for (int i = 0; i < 3; i++) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("ff_remaining", 64'(expQ.size()), 64'd5);
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ffrst_valid", out_valid, 1'b0);
    checkOutput("ffrst_busy", busy, 1'b0);
    checkOutput("ffrst_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ffrst_quiet", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

`ifdef BITMAP_DRAIN_MERGE_EN
    // Merge of 0x03 while index 4 is presented: 4, 0, 1
    out_ready = 1'b0;
    applyStimulus(8'h10);
    expQ.delete();
    in_valid = 1'b1;
    in_bits  = 8'h03;
    @(negedge clk);
    checkOutput("merge_ready", in_ready, 1'b1);
    checkOutput("merge_idx", out_idx, 3'd4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bits  = '0;
    pushOne(4, 1'b0);
    pushOne(0, 1'b0);
    pushOne(1, 1'b1);
    out_ready = 1'b1;
    waitDrain(1'b0);
`else
    // in_valid held through a drain of 0x06: blocked until idle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bits   = 8'h06;
    @(negedge clk);
    checkOutput("hold_in_ready0", in_ready, 1'b1);
    pushExpected(8'h06);
    @(posedge clk);
    #1;
    in_bits = 8'h81;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("hold_in_blocked", in_ready, 1'b0);
    end
    @(negedge clk);
    checkOutput("hold_in_reopen", in_ready, 1'b1);
    pushExpected(8'h81);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bits  = '0;
    waitDrain(1'b0);
`endif

    // Mixed bitmaps, including the top index, under random backpressure
    stim = '{8'h80, 8'hFF, 8'h5A, 8'h81};
    for (int i = 0; i < 5; i++) stim.push_back(WIDTH'($urandom));
    foreach (stim[i]) begin
      applyStimulus(stim[i]);
      waitDrain(1'b1);
    end

    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitmap_drain.md
BITMAP_DRAIN -- requirements
Module: bitmap_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the request bitmap width (legal range 2..64).
REQ-002 SHALL have parameter IDXW, default $clog2(WIDTH), meaning the output index width; it is derived and never overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  a bitmap is offered.
REQ-006 SHALL have port in_ready  output  1  a bitmap is accepted this cycle when in_valid is also high.
REQ-007 SHALL have port in_bits  input  WIDTH  offered request bitmap.
REQ-008 SHALL have port out_valid  output  1  out_idx holds a pending request.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_idx this cycle.
REQ-010 SHALL have port out_idx  output  IDXW  binary index of the served request bit.
REQ-011 SHALL have port out_last  output  1  out_idx is the final pending bit.
REQ-012 SHALL have port busy  output  1  the state machine is not IDLE.

Function
REQ-013 SHALL implement the states IDLE and DRAIN, held in a registered state variable.
REQ-014 SHALL, in IDLE, drive in_ready=1 and out_valid=0.
REQ-015 SHALL, on in_valid&in_ready with a nonzero in_bits, load the pending register and enter DRAIN on the next edge.
REQ-016 SHALL, on acceptance of an all-zero in_bits, stay in IDLE with no output activity.
REQ-017 SHALL, in DRAIN, drive out_valid=1 and out_idx=lowest-numbered set bit of pending (lowest bit first); a bitmap accepted at edge N gives its first out_valid in the cycle after edge N.
REQ-018 SHALL drive out_idx and out_last entirely from registers.
REQ-019 SHALL hold out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on out_valid&out_ready, clear the served bit and present the next lowest pending bit in the following cycle, giving a throughput of one index per cycle under continuous out_ready.
REQ-021 SHALL assert out_last exactly when the served bit is the only bit set in pending.
REQ-022 SHALL return to IDLE on the edge where the out_last beat completes, with in_ready=1 in the next cycle.
REQ-023 SHALL serve index WIDTH-1 correctly; an all-ones bitmap yields the sequence 0..WIDTH-1 with out_last on WIDTH-1.

Reset
REQ-024 SHALL, on reset high at a clock edge, set state=IDLE, clear pending, and set out_valid=0, out_idx=0, out_last=0, busy=0, in_ready=1.
REQ-025 SHALL, on reset asserted mid-DRAIN, discard all pending bits with no further out_valid.
REQ-026 SHALL give reset priority over any simultaneous handshake.

Configuration
REQ-027 SHALL compile the merge feature only when macro BITMAP_DRAIN_MERGE_EN is defined.
REQ-028 SHALL, with BITMAP_DRAIN_MERGE_EN defined, keep in_ready=1 in DRAIN and OR accepted in_bits into pending.
REQ-029 SHALL, with BITMAP_DRAIN_MERGE_EN defined, not change the currently presented out_idx because of merged bits; merged bits affect only later selections.
REQ-030 SHALL, with BITMAP_DRAIN_MERGE_EN defined, leave a merged bit that equals the index served in the same cycle set, so that index is served again later.
REQ-031 SHALL, with BITMAP_DRAIN_MERGE_EN defined, recompute out_last including merged bits and cancel the return to IDLE if a merge lands on the out_last beat.
REQ-032 SHALL, without BITMAP_DRAIN_MERGE_EN, drive in_ready=0 throughout DRAIN.

Verification
REQ-033 SHALL cover: WIDTH=8, in_bits=8'b1010_0100, out_ready=1 -> out_idx 2,5,7 on three consecutive cycles, out_last only on 7, busy drops the next cycle.
REQ-034 SHALL cover: in_bits=8'h01 with out_ready held 0 for 5 cycles, then 1 -> out_idx=0 and out_last=1 stable for 6 cycles, a single transfer, then IDLE.
REQ-035 SHALL cover: in_bits=8'h00 accepted -> busy stays 0, out_valid never asserts, in_ready stays 1.
REQ-036 SHALL cover: in_bits=8'hFF draining, reset pulsed after the 3rd transfer -> the next cycle has out_valid=0, busy=0, in_ready=1, and no further indices.
REQ-037 SHALL cover, with BITMAP_DRAIN_MERGE_EN: in_bits=8'h10, then in_bits=8'h03 merged during the first beat -> indices 4,0,1 with out_last on 1.
REQ-038 SHALL cover, without BITMAP_DRAIN_MERGE_EN: in_valid held high during DRAIN of 8'h06 -> in_ready=0 until the cycle after index 2 completes, then the new bitmap is accepted.
